inst_queue_param: RTL and testbench

Parametrised instruction queue between the instruction fetcher and the decoder. It buffers fetched instruction/PC/prediction triples and issues one entry per cycle to the decoder when ROB, RS and LS queue can all accept. It uses a full-capacity occupancy counter (no wasted slot), a configurable skid margin on the fetch-side ready, and a sticky overflow flag. It is flushed by the ROB on misprediction.

---
 rtl/inst_queue_param_pkg.sv | 13 +
 rtl/inst_queue_param_if.sv | 49 ++++
 rtl/inst_queue_param_iq_storage.sv | 28 ++
 rtl/inst_queue_param.sv | 116 +++++++++++
 tb/tb_inst_queue_param.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_queue_param_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
// Default geometry and the enable/disable encodings used by its RTL.
package inst_queue_param_pkg;

   localparam int unsigned IQ_DEPTH          = 16;
   localparam int unsigned IQ_SKID           = 1;
   localparam int unsigned INSTRUCTION_WIDTH = 32;
   localparam int unsigned ADDRESS_WIDTH     = 32;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/inst_queue_param_if.sv
// Fetch, decode, downstream-ready and status signals of the
// instruction queue; master drives the inputs, slave is the queue.
interface inst_queue_param_if #(
   parameter int DEPTH  = 16,
   parameter int INST_W = 32,
   parameter int ADDR_W = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              rdy_in;
   logic              rob_flush_in;
   logic              rob_rdy_in;
   logic              rs_rdy_in;
   logic              lsqueue_rdy_in;
   logic              ifetch_en_in;
   logic [INST_W-1:0] ifetch_inst_in;
   logic [ADDR_W-1:0] ifetch_pc_in;
   logic              ifetch_pred_in;
   logic              ifetch_rdy_out;
   logic              decoder_en_out;
   logic [INST_W-1:0] decoder_inst_out;
   logic [ADDR_W-1:0] decoder_pc_out;
   logic              decoder_pred_out;
   logic [CNT_W-1:0]  count_out;
   logic              overflow_out;

   modport master (
      output rdy_in, rob_flush_in,
      output rob_rdy_in, rs_rdy_in, lsqueue_rdy_in,
      output ifetch_en_in, ifetch_inst_in,
      output ifetch_pc_in, ifetch_pred_in,
      input  ifetch_rdy_out,
      input  decoder_en_out, decoder_inst_out,
      input  decoder_pc_out, decoder_pred_out,
      input  count_out, overflow_out
   );

   modport slave (
      input  rdy_in, rob_flush_in,
      input  rob_rdy_in, rs_rdy_in, lsqueue_rdy_in,
      input  ifetch_en_in, ifetch_inst_in,
      input  ifetch_pc_in, ifetch_pred_in,
      output ifetch_rdy_out,
      output decoder_en_out, decoder_inst_out,
      output decoder_pc_out, decoder_pred_out,
      output count_out, overflow_out
   );

endinterface

// File: rtl/inst_queue_param_iq_storage.sv
// Entry array for the instruction queue: one write port, one
// asynchronous read port, no reset (contents are don't-care).
module iq_storage
   import inst_queue_param_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int WIDTH = 65,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i == ENABLE) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue_param.sv
// Instruction queue between fetcher and decoder: full-capacity counter,
// skid margin on fetch ready, sticky overflow, ROB flush.
module inst_queue_param
   import inst_queue_param_pkg::*;
#(
   parameter int DEPTH  = IQ_DEPTH,
   parameter int INST_W = INSTRUCTION_WIDTH,
   parameter int ADDR_W = ADDRESS_WIDTH,
   parameter int SKID   = IQ_SKID
) (
   input logic               clk_in,
   input logic               rst_in,
   inst_queue_param_if.slave iq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = INST_W + ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W:0]   SKID_W = (CNT_W+1)'(SKID);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             den_q, den_d;
   logic [ENT_W-1:0] dout_q, dout_d;

   logic [ENT_W-1:0] rd_ent;
   logic [ENT_W-1:0] wr_ent;
   logic [CNT_W:0]   free_w;
   logic             down_rdy;
   logic             pop;
   logic             push;
   logic             drop;
   logic             wr_en;

   assign down_rdy = iq.rob_rdy_in & iq.rs_rdy_in & iq.lsqueue_rdy_in;
   assign pop      = (count_q != '0) & down_rdy;
   assign push     = iq.ifetch_en_in & ((count_q != FULL) | pop);
   assign drop     = iq.ifetch_en_in & (count_q == FULL) & ~pop;
   assign wr_en    = ~rst_in & iq.rdy_in & ~iq.rob_flush_in & push;
   assign wr_ent   = {iq.ifetch_inst_in, iq.ifetch_pc_in,
                      iq.ifetch_pred_in};

   iq_storage #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_storage (
      .clk_i   (clk_in),
      .we_i    (wr_en),
      .waddr_i (tail_q),
      .wdata_i (wr_ent),
      .raddr_i (head_q),
      .rdata_o (rd_ent)
   );

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      den_d   = DISABLE;
      dout_d  = dout_q;
      if (iq.rdy_in == ENABLE) begin
         if (iq.rob_flush_in == ENABLE) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (pop) begin
               dout_d = rd_ent;
               den_d  = ENABLE;
               head_d = head_q + PTR_W'(1);
            end
            if (push) begin
               tail_d = tail_q + PTR_W'(1);
            end
            if (drop) begin
               ovf_d = ENABLE;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= DISABLE;
         den_q   <= DISABLE;
         dout_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         den_q   <= den_d;
         dout_q  <= dout_d;
      end
   end

   // count never exceeds DEPTH, so the free-slot difference cannot wrap
   assign free_w = {1'b0, FULL} - {1'b0, count_q};

   assign iq.ifetch_rdy_out   = (free_w > SKID_W);
   assign iq.decoder_en_out   = den_q;
   assign iq.decoder_inst_out = dout_q[ENT_W-1 -: INST_W];
   assign iq.decoder_pc_out   = dout_q[ADDR_W:1];
   assign iq.decoder_pred_out = dout_q[0];
   assign iq.count_out        = count_q;
   assign iq.overflow_out     = ovf_q;

endmodule

// File: tb/tb_inst_queue_param.sv
// Vector table with a payload scoreboard for inst_queue_param
// (DEPTH=16, SKID=1).
module tb_inst_queue_param;

   localparam int DEPTH = 16;
   localparam int SKID  = 1;

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic        fl;
      logic        en;
      logic [31:0] pc;
      logic [2:0]  dr;
      logic        keep;
      logic [4:0]  cnt;
      logic        den;
      logic        ovf;
   } vec_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_queue_param_if #(
      .DEPTH  (DEPTH),
      .INST_W (32),
      .ADDR_W (32)
   ) bus ();

   inst_queue_param #(
      .DEPTH  (DEPTH),
      .INST_W (32),
      .ADDR_W (32),
      .SKID   (SKID)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .iq     (bus.slave)
   );

   vec_t        vecs[$];
   ent_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          idx   = 0;
   logic [31:0] last_inst = '0;
   logic [31:0] last_pc   = '0;
   logic        last_pred = 1'b0;

   function automatic vec_t mk(logic r, logic rd, logic f,
                               logic e, logic [31:0] p,
                               logic [2:0] d, logic k, int c,
                               logic de, logic ov);
      vec_t v;
      v.rst  = r;
      v.rdy  = rd;
      v.fl   = f;
      v.en   = e;
      v.pc   = p;
      v.dr   = d;
      v.keep = k;
      v.cnt  = 5'(c);
      v.den  = de;
      v.ovf  = ov;
      return v;
   endfunction

   function automatic logic [31:0] inst_of(logic [31:0] p);
      return {p[15:0], ~p[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @vec %0d: got %0h expected %0h",
                  nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      ent_t e;
      bus.rdy_in         = v.rdy;
      bus.rob_flush_in   = v.fl;
      bus.ifetch_en_in   = v.en;
      bus.ifetch_pc_in   = v.pc;
      bus.ifetch_inst_in = inst_of(v.pc);
      bus.ifetch_pred_in = v.pc[2];
      bus.rob_rdy_in     = v.dr[2];
      bus.rs_rdy_in      = v.dr[1];
      bus.lsqueue_rdy_in = v.dr[0];
      rst                = v.rst;
      if (v.rst || (v.fl && v.rdy)) sb.delete();
      if (v.en && v.keep) begin
         e.inst = inst_of(v.pc);
         e.pc   = v.pc;
         e.pred = v.pc[2];
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (v.rst) begin
         last_inst = '0;
         last_pc   = '0;
         last_pred = 1'b0;
      end
      chk("count", 64'(bus.count_out), 64'(v.cnt));
      chk("dec_en", 64'(bus.decoder_en_out), 64'(v.den));
      chk("overflow", 64'(bus.overflow_out), 64'(v.ovf));
      chk("ifetch_rdy", 64'(bus.ifetch_rdy_out),
          64'((DEPTH - int'(v.cnt)) > SKID));
      if (bus.decoder_en_out === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 64'(bus.decoder_pc_out), 64'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("pc", 64'(bus.decoder_pc_out), 64'(e.pc));
            chk("inst", 64'(bus.decoder_inst_out), 64'(e.inst));
            chk("pred", 64'(bus.decoder_pred_out), 64'(e.pred));
            last_inst = e.inst;
            last_pc   = e.pc;
            last_pred = e.pred;
         end
      end else begin
         chk("hold_pc", 64'(bus.decoder_pc_out), 64'(last_pc));
         chk("hold_inst", 64'(bus.decoder_inst_out),
             64'(last_inst));
         chk("hold_pred", 64'(bus.decoder_pred_out),
             64'(last_pred));
      end
   endtask

   initial begin
      logic o;
      bus.rdy_in         = 1'b1;
      bus.rob_flush_in   = 1'b0;
      bus.rob_rdy_in     = 1'b0;
      bus.rs_rdy_in      = 1'b0;
      bus.lsqueue_rdy_in = 1'b0;
      bus.ifetch_en_in   = 1'b0;
      bus.ifetch_inst_in = '0;
      bus.ifetch_pc_in   = '0;
      bus.ifetch_pred_in = 1'b0;

      o = 1'b0;
      vecs.push_back(mk(1, 1, 0, 0, 32'h0, 3'd0, 0, 0, 0, o));
      // three pushes, issued back-to-back one cycle later
      vecs.push_back(mk(0, 1, 0, 1, 32'h0, 3'd7, 1, 1, 0, o));
      vecs.push_back(mk(0, 1, 0, 1, 32'h4, 3'd7, 1, 1, 1, o));
      vecs.push_back(mk(0, 1, 0, 1, 32'h8, 3'd7, 1, 1, 1, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 1, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 0, o));
      // fill to 16 stalled, then a dropped 17th push
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 1, 0, 1, 32'h100 + 32'(4 * i), 3'd0,
                           1, i + 1, 0, o));
      o = 1'b1;
      vecs.push_back(mk(0, 1, 0, 1, 32'h1F0, 3'd0, 0, 16, 0, o));
      // push+pop while full, then drain across the wrap
      vecs.push_back(mk(0, 1, 0, 1, 32'h200, 3'd7, 1, 16, 1, o));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 15 - i, 1,
                           o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 0, o));
      // flush with 5 queued and a same-cycle push
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 1, 0, 1, 32'h300 + 32'(4 * i), 3'd0,
                           1, i + 1, 0, o));
      vecs.push_back(mk(0, 1, 1, 1, 32'h3F0, 3'd7, 0, 0, 0, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 0, o));
      // rdy_in low freezes everything, flush included
      vecs.push_back(mk(0, 1, 0, 1, 32'h400, 3'd0, 1, 1, 0, o));
      vecs.push_back(mk(0, 1, 0, 1, 32'h404, 3'd0, 1, 2, 0, o));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, (i == 2), 1, 32'h500 + 32'(4 * i),
                           3'd7, 0, 2, 0, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 1, 1, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 1, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 0, o));
      // rs_rdy toggling with 4 queued
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 1, 0, 1, 32'h600 + 32'(4 * i), 3'd0,
                           1, i + 1, 0, o));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 1, 0, 0, 32'h0,
                           (i % 2 == 0) ? 3'd7 : 3'd5, 0,
                           3 - i / 2, (i % 2 == 0), o));
      // reset mid-stream clears overflow and drops the queue
      vecs.push_back(mk(0, 1, 0, 1, 32'h700, 3'd0, 1, 1, 0, o));
      vecs.push_back(mk(0, 1, 0, 1, 32'h704, 3'd0, 1, 2, 0, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 1, 1, o));
      o = 1'b0;
      vecs.push_back(mk(1, 1, 0, 1, 32'h708, 3'd7, 0, 0, 0, o));
      vecs.push_back(mk(0, 1, 0, 1, 32'h800, 3'd7, 1, 1, 0, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 1, o));
      vecs.push_back(mk(0, 1, 0, 0, 32'h0, 3'd7, 0, 0, 0, o));

      @(negedge clk);
      foreach (vecs[i]) begin
         idx = i;
         apply(vecs[i]);
      end
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
